id_stage: RTL
=============

# id_stage

Instruction-decode stage of the 5-stage pipelined processor, the consumer of the IF/ID pipeline register. It decodes the fetched instruction, reads and writes the 32×32 register file, and detects load-use hazards, driving `ID_stall_i` of the fetch stage. It loads the ID/EX pipeline register, and inserts bubbles on stall or on a branch taken in MEM.

## Interface
No parameters.
- clk_i  in  1  clock; all state updates on rising edge
- n_rst_i  in  1  reset, asynchronous, active-low
- IFID_pc_i  in  32  PC+4 of fetched instruction
- IFID_ir_i  in  32  fetched instruction word
- WB_reg_write_i  in  1  write-back enable
- WB_write_reg_i  in  5  write-back destination register
- WB_write_data_i  in  32  write-back data
- MEM_ctrl_pc_src_i  in  1  branch taken in MEM; flush request
- ID_stall_o  out  1  load-use stall to fetch (combinational)
- IDEX_pc_o  out  32  registered PC+4
- IDEX_rs_data_o, IDEX_rt_data_o  out  32 each  register operands
- IDEX_imm_o  out  32  sign-extended ir[15:0]
- IDEX_rs_o, IDEX_rt_o, IDEX_rd_o  out  5 each  ir[25:21], ir[20:16], ir[15:11]
- IDEX_reg_write_o, IDEX_mem_to_reg_o, IDEX_mem_read_o, IDEX_mem_write_o, IDEX_branch_o, IDEX_alu_src_o, IDEX_reg_dst_o  out  1 each  control bits
- IDEX_alu_op_o  out  2  00 add, 01 sub, 10 use funct

## Operation
- Decode of ir[31:26]:
  - R-type 0x00: reg_write, reg_dst, alu_op=10.
  - lw 0x23: reg_write, mem_to_reg, mem_read, alu_src, alu_op=00.
  - sw 0x2B: mem_write, alu_src, alu_op=00.
  - beq 0x04: branch, alu_op=01.
  - addi 0x08: reg_write, alu_src, alu_op=00.
  - Any other opcode: all control bits 0 (NOP).
- Register file: two combinational read ports, one write port at the clock edge.
  - Register 0 reads 0 always; writes to it are ignored.
  - Write-through bypass: a read of the register being written this cycle (WB_reg_write_i=1, nonzero index) returns WB_write_data_i.
- Hazard: `ID_stall_o` = IDEX_mem_read_o & IDEX_rt_o≠0 & (IDEX_rt_o==ir[25:21], or IDEX_rt_o==ir[20:16] when the opcode is R-type, sw or beq) & ~MEM_ctrl_pc_src_i.
- ID/EX update at each edge, by priority:
  1. MEM_ctrl_pc_src_i=1: all control bits cleared (bubble); data fields are don't-care and are loaded normally.
  2. ID_stall_o=1: control bits cleared (bubble); data fields loaded normally.
  3. Otherwise: decoded controls and data fields are loaded.
- Register writes from WB are never blocked by stall or flush.

## Timing
- Reset asserted: every IDEX_* output is 0, all 32 registers are 0, and ID_stall_o is 0. Takes effect asynchronously and holds until the first edge after release.
- Reset mid-operation discards the in-flight instruction; there is no partial update.
- Latency: one cycle from IFID_* to IDEX_*.
- A WB write at edge N is visible to an ID read in the cycle ending at edge N (bypass) and in all later cycles.
- A stall lasts exactly one cycle per load-use pair. After the bubble, IDEX_mem_read_o=0, so the stall drops and the held IF/ID instruction proceeds.
- Simultaneous stall and flush: flush wins and stall is suppressed, so fetch can load the branch target.
- Back-to-back lw → lw with dependent rs: one stall only.

## Structure
- Shared package `cpu_pkg`:
  - Opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI).
  - alu_op encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT).
  - A packed control struct, reused by EX/MEM/WB.
- Sub-module `id_regfile`: 32×32 storage, async reset, two read ports with WB bypass, $0 hardwired.
- Decoder, hazard logic and ID/EX register stay in `id_stage`.

## Test plan
- Reset, then addi $1,$0,5 (IFID_ir_i=0x20010005) → next cycle reg_write=1, alu_src=1, alu_op=00, IDEX_imm_o=5, IDEX_rt_o=1.
- WB writes $3=0xDEADBEEF while IF/ID holds add $4,$3,$3 → IDEX_rs_data_o=IDEX_rt_data_o=0xDEADBEEF on that same edge.
- lw $2,0($1) followed by add $5,$2,$2 → ID_stall_o=1 for one cycle, then a bubble with all control bits 0, then add issued with its decoded controls.
- Load-use hazard with MEM_ctrl_pc_src_i=1 in the same cycle → ID_stall_o=0 and ID/EX controls cleared.
- WB write to $0 with 0xFFFFFFFF, then read $0 → 0; imm 0x8000 → IDEX_imm_o=0xFFFF8000.
- n_rst_i pulsed low mid-stream → all IDEX_* outputs are 0 immediately, and registers read 0 afterwards.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALU operation encodings and the pipeline
// control bundle carried from ID through EX/MEM/WB.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    alu_src;
    logic    reg_dst;
    alu_op_e alu_op;
  } ctrl_t;

  // Unknown opcodes decode to an all-zero bundle, i.e. a NOP.
  function automatic ctrl_t decode(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.alu_op    = ALUOP_FUNCT;
      end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_src    = 1'b1;
        c.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALUOP_SUB;
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALUOP_ADD;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Instructions whose rt field is a source operand rather than a destination.
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Signal bundle around the decode stage: IF/ID inputs, WB write port,
// MEM flush request, stall back to fetch and the ID/EX register outputs.
interface id_stage_if;
  logic [31:0] IFID_pc_i;
  logic [31:0] IFID_ir_i;
  logic        WB_reg_write_i;
  logic [4:0]  WB_write_reg_i;
  logic [31:0] WB_write_data_i;
  logic        MEM_ctrl_pc_src_i;
  // No valid/ready pair: fetch holds IF/ID for one cycle whenever
  // ID_stall_o is high, and ID inserts a bubble in that same cycle.
  logic        ID_stall_o;
  logic [31:0] IDEX_pc_o;
  logic [31:0] IDEX_rs_data_o;
  logic [31:0] IDEX_rt_data_o;
  logic [31:0] IDEX_imm_o;
  logic [4:0]  IDEX_rs_o;
  logic [4:0]  IDEX_rt_o;
  logic [4:0]  IDEX_rd_o;
  logic        IDEX_reg_write_o;
  logic        IDEX_mem_to_reg_o;
  logic        IDEX_mem_read_o;
  logic        IDEX_mem_write_o;
  logic        IDEX_branch_o;
  logic        IDEX_alu_src_o;
  logic        IDEX_reg_dst_o;
  logic [1:0]  IDEX_alu_op_o;

  modport master (
    output IFID_pc_i, IFID_ir_i, WB_reg_write_i, WB_write_reg_i, WB_write_data_i,
           MEM_ctrl_pc_src_i,
    input  ID_stall_o, IDEX_pc_o, IDEX_rs_data_o, IDEX_rt_data_o, IDEX_imm_o,
           IDEX_rs_o, IDEX_rt_o, IDEX_rd_o, IDEX_reg_write_o, IDEX_mem_to_reg_o,
           IDEX_mem_read_o, IDEX_mem_write_o, IDEX_branch_o, IDEX_alu_src_o,
           IDEX_reg_dst_o, IDEX_alu_op_o
  );

  modport slave (
    input  IFID_pc_i, IFID_ir_i, WB_reg_write_i, WB_write_reg_i, WB_write_data_i,
           MEM_ctrl_pc_src_i,
    output ID_stall_o, IDEX_pc_o, IDEX_rs_data_o, IDEX_rt_data_o, IDEX_imm_o,
           IDEX_rs_o, IDEX_rt_o, IDEX_rd_o, IDEX_reg_write_o, IDEX_mem_to_reg_o,
           IDEX_mem_read_o, IDEX_mem_write_o, IDEX_branch_o, IDEX_alu_src_o,
           IDEX_reg_dst_o, IDEX_alu_op_o
  );
endinterface

// File: rtl/id_regfile.sv
// 32x32 register file: two combinational read ports with write-through
// bypass from the write-back port; register 0 is hardwired to zero.
module id_regfile (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data
);

  logic [31:0] regs [32];
  logic        wr_live;

  assign wr_live = we && (waddr != 5'd0);

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[waddr] <= wdata;
    end
  end

  // Bypass lets WB and ID share the same cycle without a forwarding stage.
  assign rs_data = (rs_addr == 5'd0)                ? 32'd0 :
                   (wr_live && (waddr == rs_addr))  ? wdata : regs[rs_addr];
  assign rt_data = (rt_addr == 5'd0)                ? 32'd0 :
                   (wr_live && (waddr == rt_addr))  ? wdata : regs[rt_addr];

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: decoder, register file, load-use hazard
// detection and the ID/EX pipeline register with bubble insertion.
module id_stage
  import cpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        n_rst_i,
  id_stage_if.slave   bus
);

  logic [5:0]  opcode;
  logic [4:0]  ir_rs, ir_rt, ir_rd;
  logic [31:0] imm_ext;
  logic [31:0] rs_data, rt_data;
  ctrl_t       dec_ctrl;
  logic        stall;

  ctrl_t       idex_ctrl_q;
  logic [31:0] idex_pc_q, idex_rs_data_q, idex_rt_data_q, idex_imm_q;
  logic [4:0]  idex_rs_q, idex_rt_q, idex_rd_q;

  assign opcode   = bus.IFID_ir_i[31:26];
  assign ir_rs    = bus.IFID_ir_i[25:21];
  assign ir_rt    = bus.IFID_ir_i[20:16];
  assign ir_rd    = bus.IFID_ir_i[15:11];
  assign imm_ext  = {{16{bus.IFID_ir_i[15]}}, bus.IFID_ir_i[15:0]};
  assign dec_ctrl = decode(opcode);

  id_regfile u_regfile (
    .clk_i   (clk_i),
    .n_rst_i (n_rst_i),
    .we      (bus.WB_reg_write_i),
    .waddr   (bus.WB_write_reg_i),
    .wdata   (bus.WB_write_data_i),
    .rs_addr (ir_rs),
    .rt_addr (ir_rt),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

  // A taken branch squashes this instruction anyway, so stalling would only
  // delay the fetch of the branch target.
  assign stall = idex_ctrl_q.mem_read
              && (idex_rt_q != 5'd0)
              && ((idex_rt_q == ir_rs) || (reads_rt(opcode) && (idex_rt_q == ir_rt)))
              && !bus.MEM_ctrl_pc_src_i;

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      idex_ctrl_q    <= '0;
      idex_pc_q      <= '0;
      idex_rs_data_q <= '0;
      idex_rt_data_q <= '0;
      idex_imm_q     <= '0;
      idex_rs_q      <= '0;
      idex_rt_q      <= '0;
      idex_rd_q      <= '0;
    end else begin
      idex_ctrl_q    <= (bus.MEM_ctrl_pc_src_i || stall) ? ctrl_t'('0) : dec_ctrl;
      idex_pc_q      <= bus.IFID_pc_i;
      idex_rs_data_q <= rs_data;
      idex_rt_data_q <= rt_data;
      idex_imm_q     <= imm_ext;
      idex_rs_q      <= ir_rs;
      idex_rt_q      <= ir_rt;
      idex_rd_q      <= ir_rd;
    end
  end

  assign bus.ID_stall_o        = stall;
  assign bus.IDEX_pc_o         = idex_pc_q;
  assign bus.IDEX_rs_data_o    = idex_rs_data_q;
  assign bus.IDEX_rt_data_o    = idex_rt_data_q;
  assign bus.IDEX_imm_o        = idex_imm_q;
  assign bus.IDEX_rs_o         = idex_rs_q;
  assign bus.IDEX_rt_o         = idex_rt_q;
  assign bus.IDEX_rd_o         = idex_rd_q;
  assign bus.IDEX_reg_write_o  = idex_ctrl_q.reg_write;
  assign bus.IDEX_mem_to_reg_o = idex_ctrl_q.mem_to_reg;
  assign bus.IDEX_mem_read_o   = idex_ctrl_q.mem_read;
  assign bus.IDEX_mem_write_o  = idex_ctrl_q.mem_write;
  assign bus.IDEX_branch_o     = idex_ctrl_q.branch;
  assign bus.IDEX_alu_src_o    = idex_ctrl_q.alu_src;
  assign bus.IDEX_reg_dst_o    = idex_ctrl_q.reg_dst;
  assign bus.IDEX_alu_op_o     = idex_ctrl_q.alu_op;

endmodule
